// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared raster timing types, pattern codes and bar colours
package video_timing_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } vtg_state_e;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_RAMP  = 2'd3;

    localparam logic [23:0] SOLID_GREY = 24'h808080;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - combinational test pattern from pixel column, cell parity and pattern code
module video_pattern_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_WIDTH = 1920,
    parameter int HW      = 12
) (
    input  logic [HW-1:0] x,
    input  logic          cell_par,
    input  logic [1:0]    pat,
    output logic [23:0]   data
);

    localparam logic [HW-1:0] BAR_W = HW'(H_WIDTH / 8);

    logic [HW-1:0] bar_idx;

    always_comb begin
        bar_idx = x / BAR_W;
        data    = SOLID_GREY;
        unique case (pat)
            PAT_SOLID: data = SOLID_GREY;
            // Remainder pixels past 8*BAR_W fall into the last (black) bar
            PAT_BARS:  data = bar_color((bar_idx > HW'(7)) ? 3'd7 : bar_idx[2:0]);
            PAT_CHECK: data = cell_par ? 24'h000000 : 24'hFFFFFF;
            default:   data = {3{8'(x)}};
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with registered hs/vs/de and selectable test pattern
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter int KH       = 30,
    parameter int KV       = 30
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [1:0]  pattern_i,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic        vout_de_o,
    output logic [23:0] vout_data_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam int HW  = $clog2(H_TOTAL + 1);
    localparam int VW  = $clog2(V_TOTAL + 1);
    localparam int KHW = $clog2(KH + 1);
    localparam int KVW = $clog2(KV + 1);

    localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT   = HW'(H_WIDTH);
    localparam logic [HW-1:0]  HS_BEG  = HW'(H_START);
    localparam logic [HW-1:0]  HS_END  = HW'(H_START + H_SYNC);
    localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT   = VW'(V_HEIGHT);
    localparam logic [VW-1:0]  VS_BEG  = VW'(V_START);
    localparam logic [VW-1:0]  VS_END  = VW'(V_START + V_SYNC);
    localparam logic [KHW-1:0] KH_LAST = KHW'(KH - 1);
    localparam logic [KVW-1:0] KV_LAST = KVW'(KV - 1);

    if (!(H_WIDTH < H_START && H_START + H_SYNC <= H_TOTAL &&
          V_HEIGHT < V_START && V_START + V_SYNC <= V_TOTAL && H_WIDTH >= 8)) begin : g_param_check
        $error("video_timing_gen: illegal timing geometry");
    end

    vtg_state_e     state;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic [KHW-1:0] kh_cnt;
    logic [KVW-1:0] kv_cnt;
    logic           col_par;
    logic           row_par;
    logic [1:0]     pat_q;
    logic [15:0]    frame_cnt;

    logic        running;
    logic        h_last;
    logic        frame_last;
    logic        at_origin;
    logic        pat_load;
    logic [1:0]  pat_sel;
    logic        de_c;
    logic        hs_c;
    logic        vs_c;
    logic [23:0] pat_data;

    always_comb begin
        running    = (state != ST_IDLE);
        h_last     = (h_cnt == H_LAST);
        frame_last = h_last && (v_cnt == V_LAST);
        at_origin  = (h_cnt == '0) && (v_cnt == '0);
        // Pattern is taken at frame origin so the first pixel already uses it
        pat_load   = at_origin && ((state == ST_RUN) || en_i);
        pat_sel    = pat_load ? pattern_i : pat_q;
        de_c       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_c       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            pat_q <= PAT_SOLID;
        end else begin
            if (pat_load) pat_q <= pattern_i;
            unique case (state)
                ST_IDLE: if (en_i) state <= ST_RUN;
                ST_RUN:  if (!en_i) state <= frame_last ? ST_IDLE : ST_STOP;
                ST_STOP: begin
                    if (en_i)            state <= ST_RUN;
                    else if (frame_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Raster and checkerboard cell counters; the last pixel always wraps to origin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            kh_cnt    <= '0;
            kv_cnt    <= '0;
            col_par   <= 1'b0;
            row_par   <= 1'b0;
            frame_cnt <= '0;
        end else if (running) begin
            if (h_last) begin
                h_cnt   <= '0;
                kh_cnt  <= '0;
                col_par <= 1'b0;
                if (v_cnt == V_LAST) begin
                    v_cnt     <= '0;
                    kv_cnt    <= '0;
                    row_par   <= 1'b0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if (kv_cnt == KV_LAST) begin
                        kv_cnt  <= '0;
                        row_par <= ~row_par;
                    end else begin
                        kv_cnt <= kv_cnt + 1'b1;
                    end
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
                if (kh_cnt == KH_LAST) begin
                    kh_cnt  <= '0;
                    col_par <= ~col_par;
                end else begin
                    kh_cnt <= kh_cnt + 1'b1;
                end
            end
        end
    end

    video_pattern_gen #(
        .H_WIDTH (H_WIDTH),
        .HW      (HW)
    ) u_pattern (
        .x        (h_cnt),
        .cell_par (col_par ^ row_par),
        .pat      (pat_sel),
        .data     (pat_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vout_hs_o     <= 1'b0;
            vout_vs_o     <= 1'b0;
            vout_de_o     <= 1'b0;
            vout_data_o   <= '0;
            frame_start_o <= 1'b0;
        end else if (!running) begin
            vout_hs_o     <= 1'b0;
            vout_vs_o     <= 1'b0;
            vout_de_o     <= 1'b0;
            vout_data_o   <= '0;
            frame_start_o <= 1'b0;
        end else begin
            vout_hs_o     <= hs_c;
            vout_vs_o     <= vs_c;
            vout_de_o     <= de_c;
            vout_data_o   <= de_c ? pat_data : 24'h000000;
            frame_start_o <= at_origin;
        end
    end

    assign frame_cnt_o = frame_cnt;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster transmitter for the pixel stream that the dark-mode pipeline consumes. It generates registered hs/vs/de timing and a selectable 24-bit test pattern from the same horizontal and vertical geometry the pipeline parses. It sits in front of the pipeline's video input, and in standalone builds drives the output port. Its main uses are bring-up without an HDMI source and closed-loop verification of the block and cursor logic.

## Interface
- H_WIDTH, 1920, active pixels per line
- H_START, 2008, horizontal counter value where hs asserts
- H_SYNC, 44, hs pulse width in pixels
- H_TOTAL, 2200, pixels per line
- V_HEIGHT, 1080, active lines per frame
- V_START, 1084, line where vs asserts
- V_SYNC, 5, vs pulse width in lines
- V_TOTAL, 1125, lines per frame
- KH, 30, checkerboard cell width
- KV, 30, checkerboard cell height
- clk_i  in  1  pixel clock; the block uses this one clock only
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  request to run
- pattern_i  in  2  pattern select, latched at frame start
- vout_hs_o  out  1  hsync, active high
- vout_vs_o  out  1  vsync, active high
- vout_de_o  out  1  data enable
- vout_data_o  out  24  pixel data {R,G,B}; 0 when de=0
- frame_start_o  out  1  one-cycle pulse, aligned with the first de of a frame
- frame_cnt_o  out  16  completed frames, wraps at 65535→0

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1.
  - v_cnt runs 0..V_TOTAL-1.
  - v_cnt increments when h_cnt wraps.
  - Both counters advance only in RUN or STOP.
- Decode from the current counters:
  - de = (h_cnt < H_WIDTH) && (v_cnt < V_HEIGHT)
  - hs = H_START ≤ h_cnt < H_START+H_SYNC
  - vs = V_START ≤ v_cnt < V_START+V_SYNC, held for whole lines
- FSM states: IDLE, RUN, STOP.
  - IDLE → RUN when en_i=1. Counters are already 0 in IDLE.
  - RUN → STOP when en_i=0. The current frame always completes.
  - STOP → RUN if en_i returns to 1 before the end of the frame.
  - STOP → IDLE at the last pixel of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1). Counters return to 0.
  - RUN stays in RUN at the last pixel and wraps to a new frame.
- In IDLE, all outputs are 0 and counters hold at 0.
- pattern_i is sampled into pat_q:
  - when (h_cnt,v_cnt)=(0,0) and the FSM is in RUN or entering RUN;
  - mid-frame changes are ignored.
- Patterns, with x = h_cnt and y = v_cnt:
  - 0: solid 0x808080.
  - 1: eight colour bars, bar index = x / (H_WIDTH/8) with integer division, clamped to 7. Colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 2: checkerboard. Cell column and cell row are tracked by sub-counters (no dividers). A cell is FFFFFF when cell_col XOR cell_row = 0, otherwise 000000.
  - 3: horizontal ramp, R=G=B=x[7:0].
- frame_cnt increments at the last pixel of every frame that completes. Reset clears it; disabling does not.

## Timing
- All outputs are registered. Each output reflects the counter state from one cycle earlier, so latency from counter to pins is 1.
- First de after en_i rises:
  - en_i is sampled at cycle 0 (IDLE→RUN);
  - counters are (0,0) at cycle 1;
  - vout_de_o=1 and frame_start_o=1 at cycle 2.
- Per line: de is high for H_WIDTH cycles, and hs rises H_START cycles after de rises.
- Reset assertion has immediate effect, even mid-frame:
  - all outputs go to 0;
  - FSM goes to IDLE;
  - counters, pat_q and frame_cnt clear;
  - the first cycle after release is IDLE.
- The checkerboard sub-counters reset at h_cnt=0 (column) and at the frame wrap (row). They stay correct when H_WIDTH is not a multiple of KH (partial last cell).
- Parameter legality, checked by an elaboration assertion:
  - H_WIDTH < H_START;
  - H_START+H_SYNC ≤ H_TOTAL;
  - the same constraints vertically;
  - H_WIDTH ≥ 8.

## Structure
- A shared timing package holds:
  - the FSM state enum (IDLE/RUN/STOP);
  - pattern code constants;
  - the bar colour table.
- The checkerboard and ramp are computed inline.
- One sub-module, video_pattern_gen, is natural: it is combinational from (x, y, cell parity, pat_q) to 24-bit data, and the top-level output register captures its result.

## Test plan
All scenarios use small parameters: H_WIDTH 8, H_START 10, H_SYNC 2, H_TOTAL 12, V_HEIGHT 4, V_START 5, V_SYNC 1, V_TOTAL 6, KH 2, KV 2.
- Start: en_i=1 at cycle 0 → frame_start_o and de=1 at cycle 2. de stays high 8 cycles. hs is high in cycles 12–13. vs is high for 12 cycles starting 60 cycles after first de.
- Pattern 1: expected de-active data per line is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Pattern 2: line 0 reads FF,FF,00,00,FF,FF,00,00 (per channel). Line 2 is the inverse.
- Mid-frame pattern_i change from 3 to 0 → no data change until the next frame_start_o.
- en_i drops mid-frame → the frame completes with all 72 cycles. frame_cnt_o increments to 1, then all outputs stay 0. Re-asserting en_i restarts at (0,0).
- rst_ni pulled low mid-line → outputs are 0 within the same cycle. After release with en_i=1, the first de appears 2 cycles later and frame_cnt_o=0.
